fc_argmax_reader: RTL and testbench

Downstream classification stage for the fully connected pipeline. After the second FC layer signals completion, this block reads the BCK_CELL signed 16-bit output-cell values from the final-layer memory and finds the index of the largest value. It then presents the winning class index on a valid/ready output port. The block drives only the memory read port; it never writes.

---
 rtl/fc_argmax_reader.sv | 175 +++++++++++++++++
 tb/tb_fc_argmax_reader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fc_argmax_reader.sv
// fc_argmax_reader: scans the final FC layer's output cells and reports the index of the largest one.
//
// Reads BCK_CELL signed 16-bit words from BASE_ADDR.. over a fixed-latency
// read port, tracks the running maximum (lowest index wins ties) and presents
// the winning class on a valid/ready port.
//
// Optional build macro: ARGMAX_SCORE_OUT_EN adds the max_score output port.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      run request pulse, honoured only in IDLE
//   rd_en      read request valid
//   rd_addr    read address (BASE_ADDR + cell index)
//   rd_data    read data, two's complement, RD_LAT cycles after the request
//   busy       high whenever the block is not IDLE
//   out_valid  result valid (HOLD state)
//   out_ready  consumer accepts the result
//   class_idx  index of the maximum cell
//   max_score  value of the maximum cell (ARGMAX_SCORE_OUT_EN only)
module fc_argmax_reader #(
    parameter int          BCK_CELL  = 5,
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        rd_en,
    output logic [15:0] rd_addr,
    input  logic [15:0] rd_data,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  class_idx
`ifdef ARGMAX_SCORE_OUT_EN
    ,
    output logic [15:0] max_score
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    localparam logic [7:0] LAST = 8'(BCK_CELL - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        rd_en_q, rd_en_d;
    logic [15:0] rd_addr_q, rd_addr_d;
    logic        best_vld_q, best_vld_d;
    logic [7:0]  best_idx_q, best_idx_d;
    logic [15:0] best_val_q, best_val_d;
    logic [7:0]  class_q, class_d;
`ifdef ARGMAX_SCORE_OUT_EN
    logic [15:0] score_q, score_d;
`endif

    // Delay line: tags each request with its cell index so the returning
    // word can be matched RD_LAT cycles later.
    logic [RD_LAT-1:0] tag_vld_q;
    logic [7:0]        tag_idx_q [RD_LAT];

    logic        tag_vld;
    logic [7:0]  tag_idx;
    logic        take;
    logic        last_ret;
    logic [7:0]  nxt_idx;
    logic [15:0] nxt_val;

    always_comb begin
        tag_vld  = tag_vld_q[RD_LAT-1];
        tag_idx  = tag_idx_q[RD_LAT-1];
        // Strictly greater keeps the earlier (lower) index on ties.
        take     = tag_vld && (!best_vld_q || ($signed(rd_data) > $signed(best_val_q)));
        nxt_idx  = take ? tag_idx : best_idx_q;
        nxt_val  = take ? rd_data : best_val_q;
        last_ret = tag_vld && (tag_idx == LAST);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_en_d    = rd_en_q;
        rd_addr_d  = rd_addr_q;
        best_vld_d = best_vld_q | tag_vld;
        best_idx_d = nxt_idx;
        best_val_d = nxt_val;
        class_d    = class_q;
`ifdef ARGMAX_SCORE_OUT_EN
        score_d    = score_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d      = 8'd0;
                best_vld_d = 1'b0;
                if (start) begin
                    state_d   = READ;
                    rd_en_d   = 1'b1;
                    rd_addr_d = BASE_ADDR;
                end
            end
            READ: begin
                if (cnt_q == LAST) begin
                    state_d = DRAIN;
                    rd_en_d = 1'b0;
                end else begin
                    cnt_d     = cnt_q + 8'd1;
                    rd_addr_d = BASE_ADDR + {8'd0, cnt_q} + 16'd1;
                end
            end
            DRAIN: begin
                // The edge sampling the last cell also publishes the result.
                if (last_ret) begin
                    state_d = HOLD;
                    class_d = nxt_idx;
`ifdef ARGMAX_SCORE_OUT_EN
                    score_d = nxt_val;
`endif
                end
            end
            default: begin
                if (out_ready) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= BASE_ADDR;
            best_vld_q <= 1'b0;
            best_idx_q <= 8'd0;
            best_val_q <= 16'd0;
            class_q    <= 8'd0;
`ifdef ARGMAX_SCORE_OUT_EN
            score_q    <= 16'd0;
`endif
            tag_vld_q  <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_idx_q[i] <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            best_vld_q <= best_vld_d;
            best_idx_q <= best_idx_d;
            best_val_q <= best_val_d;
            class_q    <= class_d;
`ifdef ARGMAX_SCORE_OUT_EN
            score_q    <= score_d;
`endif
            tag_vld_q[0] <= rd_en_q;
            tag_idx_q[0] <= cnt_q;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == HOLD);
    assign class_idx = class_q;
`ifdef ARGMAX_SCORE_OUT_EN
    assign max_score = score_q;
`endif

endmodule

// File: tb/tb_fc_argmax_reader.sv
// tb_fc_argmax_reader: table-driven scoreboard bench for fc_argmax_reader (default and swept parameters).
module tb_fc_argmax_reader;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic        start, rd_en, busy, out_valid, out_ready;
    logic [15:0] rd_addr, rd_data, max_score;
    logic [7:0]  class_idx;

    logic        b_start, b_rd_en, b_busy, b_out_valid, b_out_ready;
    logic [15:0] b_rd_addr, b_rd_data, b_max_score;
    logic [7:0]  b_class_idx;

    fc_argmax_reader dut (
        .clk(clk), .reset_n(reset_n), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .class_idx(class_idx)
`ifdef ARGMAX_SCORE_OUT_EN
        , .max_score(max_score)
`endif
    );

    fc_argmax_reader #(.BCK_CELL(1), .BASE_ADDR(16'h0020), .RD_LAT(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(b_start), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
        .rd_data(b_rd_data), .busy(b_busy), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .class_idx(b_class_idx)
`ifdef ARGMAX_SCORE_OUT_EN
        , .max_score(b_max_score)
`endif
    );

`ifndef ARGMAX_SCORE_OUT_EN
    assign max_score   = 16'd0;
    assign b_max_score = 16'd0;
`endif

    // Memory models: RD_LAT-stage registered read pipelines.
    logic [15:0] mem_a [8];
    logic [15:0] mem_b;
    logic [15:0] pa;
    logic [15:0] pb [3];
    always @(posedge clk) begin
        pa    <= mem_a[rd_addr[2:0]];
        pb[0] <= (b_rd_addr == 16'h0020) ? mem_b : 16'hDEAD;
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign rd_data   = pa;
    assign b_rd_data = pb[2];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] c [5];
        logic [7:0]  idx;
        logic [15:0] sc;
    } vec_t;

    typedef struct {
        logic [7:0]  idx;
        logic [15:0] sc;
    } res_t;

    vec_t vecs [7];
    res_t sbq [$];
    res_t mon_r;

    // Scoreboard: compare each completed handshake against the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                mon_r = sbq.pop_front();
                chk("class_idx", {24'd0, class_idx}, {24'd0, mon_r.idx});
`ifdef ARGMAX_SCORE_OUT_EN
                chk("max_score", {16'd0, max_score}, {16'd0, mon_r.sc});
`endif
            end
        end
    end

    task automatic load(input int v);
        for (int i = 0; i < 5; i++) mem_a[i] = vecs[v].c[i];
    endtask

    task automatic run_vec(input int v);
        int lat;
        res_t r;
        load(v);
        r.idx = vecs[v].idx;
        r.sc  = vecs[v].sc;
        @(posedge clk); #1 start = 1'b1;
        sbq.push_back(r);
        @(posedge clk); #1 start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("rd_first", {15'd0, rd_en, rd_addr}, {15'd0, 1'b1, 16'h0000});
        lat = 0;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        chk("latency", lat, 6);
        @(posedge clk); #1;
        chk("idle_after_hs", {30'd0, busy, out_valid}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{'{16'd3, 16'hFFFE, 16'd7, 16'd1, 16'd0}, 8'd2, 16'd7};
        vecs[1] = '{'{16'd3, 16'hFFFE, 16'd7, 16'd7, 16'd1}, 8'd2, 16'd7};
        vecs[2] = '{'{16'hFFFB, 16'hFFFF, 16'hFFFD, 16'hFFF7, 16'hFFFE}, 8'd1, 16'hFFFF};
        vecs[3] = '{'{16'h8000, 16'h8000, 16'h7FFF, 16'h0000, 16'h8001}, 8'd2, 16'h7FFF};
        vecs[4] = '{'{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000}, 8'd0, 16'h8000};
        vecs[5] = '{'{16'd1, 16'd9, 16'd2, 16'd3, 16'd4}, 8'd1, 16'd9};
        vecs[6] = '{'{16'd0, 16'd0, 16'd0, 16'd0, 16'd5}, 8'd4, 16'd5};
        for (int i = 0; i < 8; i++) mem_a[i] = 16'd0;
        mem_b       = 16'hFFF9;
        start       = 1'b0;
        b_start     = 1'b0;
        out_ready   = 1'b1;
        b_out_ready = 1'b1;
        reset_n     = 1'b1;
        #1 reset_n  = 1'b0;
        #1;
        chk("reset_ctrl", {29'd0, rd_en, busy, out_valid}, 32'd0);
        chk("reset_addr", {16'd0, rd_addr}, 32'h0000);
        chk("reset_idx", {24'd0, class_idx}, 32'd0);
        chk("reset_b_addr", {16'd0, b_rd_addr}, 32'h0020);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        for (int v = 0; v < 7; v++) run_vec(v);

        // Backpressure with start pulses during HOLD.
        load(0);
        out_ready = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        sbq.push_back('{8'd2, 16'd7});
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 50 && !out_valid; c++) begin
            @(posedge clk); #1;
        end
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        load(5);
        for (int c = 0; c < 10; c++) begin
            start = c[0];
            @(posedge clk); #1;
            chk("bp_hold", {22'd0, busy, out_valid, class_idx}, {22'd0, 1'b1, 1'b1, 8'd2});
        end
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("bp_release", {30'd0, busy, out_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1 chk("bp_no_restart", {30'd0, busy, rd_en}, 32'd0);

        // Reset during READ at cnt=2, then a clean run.
        load(0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("mid_addr", {15'd0, rd_en, rd_addr}, {15'd0, 1'b1, 16'h0002});
        reset_n = 1'b0;
        #1;
        chk("rst_ctrl", {29'd0, rd_en, busy, out_valid}, 32'd0);
        chk("rst_vals", {8'd0, rd_addr, class_idx}, 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            chk("rst_no_partial", {30'd0, busy, out_valid}, 32'd0);
        end
        run_vec(5);

        // Swept parameters: one cell, latency 3, base 0x20.
        begin
            int n_rd, lat;
            logic [7:0]  got_idx;
            logic [15:0] got_sc;
            n_rd = 0; lat = 0; got_idx = 8'hFF; got_sc = 16'd0;
            @(posedge clk); #1 b_start = 1'b1;
            @(posedge clk); #1 b_start = 1'b0;
            for (int c = 0; c < 20; c++) begin
                if (b_rd_en) begin
                    n_rd++;
                    chk("b_addr", {16'd0, b_rd_addr}, 32'h0020);
                end
                if (b_out_valid && lat == 0) begin
                    lat = c;
                    got_idx = b_class_idx;
                    got_sc  = b_max_score;
                end
                @(posedge clk); #1;
            end
            chk("b_rd_cycles", n_rd, 1);
            chk("b_latency", lat, 4);
            chk("b_idx", {24'd0, got_idx}, 32'd0);
`ifdef ARGMAX_SCORE_OUT_EN
            chk("b_score", {16'd0, got_sc}, 32'h0000FFF9);
`endif
            chk("b_idle", {31'd0, b_busy}, 32'd0);
        end

        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
